cla_addsub_pipe: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor. Next generation of the team's 8-bit combinational CLA add/sub.
- Width is split into GROUP-bit lookahead slices, with one slice resolved per pipeline stage. The slice carry is registered into the next stage.
- Valid/ready handshake on input and output, with full backpressure, one operation per cycle sustained.
- Flags: carry/no-borrow, signed overflow, zero and negative. Used as the ALU arithmetic core feeding the register-file writeback.

---
 rtl/cla_addsub_pipe_if.sv | 28 ++
 rtl/cla_addsub_pipe.sv | 163 ++++++++++++++++
 tb/tb_cla_addsub_pipe.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cla_addsub_pipe_if.sv
// Handshake and data bundle for the pipelined carry-lookahead add/sub core.
// master drives operands and out_ready; slave is the arithmetic core.
interface cla_addsub_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             AddSub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] R;
    logic             Cout;
    logic             OVR;
    logic             Zero;
    logic             Neg;

    modport master (
        output in_valid, AddSub, A, B, out_ready,
        input  in_ready, out_valid, R, Cout, OVR, Zero, Neg
    );

    modport slave (
        input  in_valid, AddSub, A, B, out_ready,
        output in_ready, out_valid, R, Cout, OVR, Zero, Neg
    );
endinterface

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead slice per
// stage, slice carry registered between stages, flags resolved in the last stage.
module cla_addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    cla_addsub_pipe_if.slave bus
);
    localparam int LAT   = WIDTH / GROUP;
    localparam int NPIPE = (LAT > 1) ? LAT - 1 : 1;
    localparam logic [WIDTH-1:0] SLICE0 = WIDTH'((1 << GROUP) - 1);

    // Fully expanded lookahead: every carry is a sum of products of g, p and cin.
    function automatic logic [GROUP:0] slice_carry(
        input logic [GROUP-1:0] p,
        input logic [GROUP-1:0] g,
        input logic             cin
    );
        logic [GROUP:0] c;
        logic           term;
        c[0] = cin;
        for (int i = 0; i < GROUP; i++) begin
            term = cin;
            for (int j = 0; j <= i; j++) term = term & p[j];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) term = term & p[m];
                c[i+1] = c[i+1] | term;
            end
        end
        return c;
    endfunction

    logic             adv;

    logic             vld_q [NPIPE];
    logic             vld_d [NPIPE];
    logic [WIDTH-1:0] a_q   [NPIPE];
    logic [WIDTH-1:0] a_d   [NPIPE];
    logic [WIDTH-1:0] b_q   [NPIPE];
    logic [WIDTH-1:0] b_d   [NPIPE];
    logic [WIDTH-1:0] r_q   [NPIPE];
    logic [WIDTH-1:0] r_d   [NPIPE];
    logic             c_q   [NPIPE];
    logic             c_d   [NPIPE];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] r_out_q, r_out_d;
    logic             cout_q, cout_d;
    logic             ovr_q, ovr_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;

    logic             st_v [LAT];
    logic [WIDTH-1:0] st_a [LAT];
    logic [WIDTH-1:0] st_b [LAT];
    logic [WIDTH-1:0] st_r [LAT];
    logic             st_c [LAT];
    logic [GROUP:0]   sl_c [LAT];
    logic [WIDTH-1:0] nx_r [LAT];

    assign adv          = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.R        = r_out_q;
    assign bus.Cout     = cout_q;
    assign bus.OVR      = ovr_q;
    assign bus.Zero     = zero_q;
    assign bus.Neg      = neg_q;

    // Stage 0 sees the bus with B already conditioned for subtract.
    always_comb begin
        for (int k = 0; k < LAT; k++) begin
            if (k == 0) begin
                st_v[k] = bus.in_valid;
                st_a[k] = bus.A;
                st_b[k] = bus.B ^ {WIDTH{bus.AddSub}};
                st_r[k] = '0;
                st_c[k] = bus.AddSub;
            end else begin
                st_v[k] = vld_q[k-1];
                st_a[k] = a_q[k-1];
                st_b[k] = b_q[k-1];
                st_r[k] = r_q[k-1];
                st_c[k] = c_q[k-1];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < LAT; k++) begin
            sl_c[k] = slice_carry(st_a[k][k*GROUP +: GROUP] ^ st_b[k][k*GROUP +: GROUP],
                                  st_a[k][k*GROUP +: GROUP] & st_b[k][k*GROUP +: GROUP],
                                  st_c[k]);
            nx_r[k] = st_r[k];
            nx_r[k][k*GROUP +: GROUP] = st_a[k][k*GROUP +: GROUP] ^ st_b[k][k*GROUP +: GROUP]
                                        ^ sl_c[k][GROUP-1:0];
        end
    end

    always_comb begin
        vld_d       = vld_q;
        a_d         = a_q;
        b_d         = b_q;
        r_d         = r_q;
        c_d         = c_q;
        out_valid_d = out_valid_q;
        r_out_d     = r_out_q;
        cout_d      = cout_q;
        ovr_d       = ovr_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        if (adv) begin
            // Consumed operand bits are dropped so only the pending upper slices travel on.
            for (int k = 0; k < LAT - 1; k++) begin
                vld_d[k] = st_v[k];
                a_d[k]   = st_a[k] & ~(SLICE0 << (k*GROUP));
                b_d[k]   = st_b[k] & ~(SLICE0 << (k*GROUP));
                r_d[k]   = nx_r[k];
                c_d[k]   = sl_c[k][GROUP];
            end
            out_valid_d = st_v[LAT-1];
            r_out_d     = nx_r[LAT-1];
            cout_d      = sl_c[LAT-1][GROUP];
            ovr_d       = sl_c[LAT-1][GROUP] ^ sl_c[LAT-1][GROUP-1];
            zero_d      = ~|nx_r[LAT-1];
            neg_d       = nx_r[LAT-1][WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NPIPE; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                r_q[k]   <= '0;
                c_q[k]   <= 1'b0;
            end
            out_valid_q <= 1'b0;
            r_out_q     <= '0;
            cout_q      <= 1'b0;
            ovr_q       <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            a_q         <= a_d;
            b_q         <= b_d;
            r_q         <= r_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
            r_out_q     <= r_out_d;
            cout_q      <= cout_d;
            ovr_q       <= ovr_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
        end
    end
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Directed plus randomized bench for cla_addsub_pipe, checked against an
// arithmetic reference model and an in-order expectation queue.
module tb_cla_addsub_pipe;
    localparam int W   = 16;
    localparam int G   = 4;
    localparam int LAT = W / G;

    typedef struct packed {
        logic [W-1:0] r;
        logic         cout;
        logic         ovr;
        logic         zero;
        logic         neg;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    cla_addsub_pipe_if #(.WIDTH(W)) bus ();

    cla_addsub_pipe #(.WIDTH(W), .GROUP(G)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_out    = 0;
    int   first_out_cyc = -1;
    int   last_out_cyc  = -1;
    exp_t exp_q [$];

    function automatic exp_t model(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        int unsigned ua, ub, s;
        int          sa, sb, sv;
        ua = 32'(a);
        ub = 32'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            s      = ua - ub;
            e.cout = (ua >= ub);
            sv     = sa - sb;
        end else begin
            s      = ua + ub;
            e.cout = (s > 32'h0000_FFFF);
            sv     = sa + sb;
        end
        e.r    = s[W-1:0];
        e.ovr  = (sv > 32767) || (sv < -32768);
        e.zero = (e.r == '0);
        e.neg  = e.r[W-1];
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_out(input logic ordy);
        exp_t e;
        if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("no_stale_result", 32'(bus.out_valid), 32'd0);
            end else begin
                e = exp_q[0];
                check("R",    32'(bus.R),    32'(e.r));
                check("Cout", 32'(bus.Cout), 32'(e.cout));
                check("OVR",  32'(bus.OVR),  32'(e.ovr));
                check("Zero", 32'(bus.Zero), 32'(e.zero));
                check("Neg",  32'(bus.Neg),  32'(e.neg));
                if (ordy) begin
                    void'(exp_q.pop_front());
                    n_out++;
                    if (first_out_cyc < 0) first_out_cyc = cyc;
                    last_out_cyc = cyc;
                end
            end
        end
    endtask

    // One clock cycle: drive at the falling edge, observe 1 time unit later.
    task automatic step(input logic iv, input logic sub, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ordy, output logic acc);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.AddSub    = sub;
        bus.A         = a;
        bus.B         = b;
        bus.out_ready = ordy;
        #1;
        acc = iv & bus.in_ready;
        check_out(ordy);
        if (acc) exp_q.push_back(model(sub, a, b));
        cyc++;
    endtask

    task automatic run_one(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
        logic acc;
        step(1'b1, sub, a, b, 1'b1, acc);
        check("single_accept", 32'(acc), 32'd1);
        for (int i = 1; i <= LAT; i++) begin
            step(1'b0, 1'(~sub), 16'($urandom), 16'($urandom), 1'b1, acc);
            check($sformatf("latency_vld_%0d", i), 32'(bus.out_valid), (i == LAT) ? 32'd1 : 32'd0);
        end
        check("single_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic reset_counters();
        n_out         = 0;
        first_out_cyc = -1;
        last_out_cyc  = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         acc;
        logic [W-1:0] va [8];
        logic [W-1:0] vb [8];
        logic         vs [8];
        logic [W-1:0] snap;
        int           idx;
        int           r;

        bus.in_valid  = 1'b0;
        bus.AddSub    = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_R",         32'(bus.R),         32'd0);
        check("rst_Cout",      32'(bus.Cout),      32'd0);
        check("rst_OVR",       32'(bus.OVR),       32'd0);
        check("rst_Zero",      32'(bus.Zero),      32'd0);
        check("rst_Neg",       32'(bus.Neg),       32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        run_one(1'b0, 16'h7FFF, 16'h0001);
        run_one(1'b0, 16'hFFFF, 16'h0001);
        run_one(1'b1, 16'h0000, 16'h0001);
        run_one(1'b1, 16'h8000, 16'h0001);
        run_one(1'b1, 16'h5A5A, 16'h5A5A);

        // Back-to-back stream, consumer always ready.
        for (int i = 0; i < 8; i++) begin
            va[i] = 16'($urandom);
            vb[i] = 16'($urandom);
            vs[i] = 1'($urandom_range(0, 1));
        end
        reset_counters();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, vs[i], va[i], vb[i], 1'b1, acc);
            check("stream_in_ready", 32'(bus.in_ready), 32'd1);
        end
        for (int i = 0; i < 10 && exp_q.size() != 0; i++)
            step(1'b0, 1'b0, 16'($urandom), 16'($urandom), 1'b1, acc);
        check("stream_count", 32'(n_out), 32'd8);
        check("stream_consecutive", 32'(last_out_cyc - first_out_cyc), 32'd7);

        // Same kind of stream with a 3-cycle consumer stall once results flow.
        for (int i = 0; i < 8; i++) begin
            va[i] = 16'($urandom);
            vb[i] = 16'($urandom);
            vs[i] = 1'($urandom_range(0, 1));
        end
        reset_counters();
        idx  = 0;
        r    = 0;
        snap = '0;
        while ((idx < 8 || exp_q.size() != 0) && r < 40) begin
            step(idx < 8, vs[idx % 8], va[idx % 8], vb[idx % 8], !(r >= 5 && r <= 7), acc);
            if (r < 5) check("prestall_in_ready", 32'(bus.in_ready), 32'd1);
            if (r >= 5 && r <= 7) begin
                check("stall_in_ready",  32'(bus.in_ready),  32'd0);
                check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            end
            if (r == 5) snap = bus.R;
            if (r == 7) check("stall_hold_R", 32'(bus.R), 32'(snap));
            if (acc) idx++;
            r++;
        end
        check("stall_finished_in_budget", 32'(r < 40), 32'd1);
        check("stall_count", 32'(n_out), 32'd8);

        // Reset with three operations in flight, the oldest held at the output.
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'(i), 16'($urandom), 16'($urandom), 1'b1, acc);
        step(1'b0, 1'b0, '0, '0, 1'b0, acc);
        step(1'b0, 1'b0, '0, '0, 1'b0, acc);
        check("prereset_out_valid", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_R",         32'(bus.R),         32'd0);
        check("midrst_flags",     32'({bus.Cout, bus.OVR, bus.Zero, bus.Neg}), 32'd0);
        check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        run_one(1'b0, 16'h1234, 16'h1111);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 16'($urandom), 16'($urandom), 1'b1, acc);
            check("postrst_idle", 32'(bus.out_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
